// File: rtl/addsub_seq_pkg.sv
// Shared types and default sizing for the multi-precision add/subtract sequencer.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_DEFAULT     = 4;
  localparam int WORDS_DEFAULT = 4;

endpackage

// File: rtl/addsub_slice.sv
// Combinational N-bit adder-subtractor slice; y is inverted when sub=1 and the
// caller supplies the carry-in (1 on the first slice of a subtract).
module addsub_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [N-1:0] y_eff;
  logic [N:0]   sum;

  assign y_eff = sub ? ~y : y;
  assign sum   = {1'b0, x} + {1'b0, y_eff} + (N+1)'(cin);
  assign s     = sum[N-1:0];
  assign cout  = sum[N];
  // The MSB sum bit is x^y^cin at that position, so cin can be recovered from it.
  assign c_msb = x[N-1] ^ y_eff[N-1] ^ s[N-1];

endmodule

// File: rtl/addsub_seq.sv
// Sequencer driving one N-bit addsub_slice over WORDS cycles, LSB slice first.
// Optional zero flag port and logic when ADDSUB_SEQ_ZFLAG_EN is defined.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter  int N     = N_DEFAULT,
  parameter  int WORDS = WORDS_DEFAULT,
  localparam int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
`ifdef ADDSUB_SEQ_ZFLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   a_words [WORDS];
  logic [N-1:0]   b_words [WORDS];
  logic [N-1:0]   slice_s;
  logic           slice_cout, slice_cmsb;
  logic           accept, running, last_slice;

  assign accept     = (state_q == IDLE) && start;
  assign running    = (state_q == RUN);
  assign last_slice = (idx_q == IW'(WORDS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign a_words[gi] = a_q[gi*N +: N];
      assign b_words[gi] = b_q[gi*N +: N];
      assign result_d[gi*N +: N] = (running && idx_q == IW'(gi)) ? slice_s
                                                                 : result_q[gi*N +: N];
    end
  endgenerate

  addsub_slice #(.N(N)) u_slice (
    .x     (a_words[idx_q]),
    .y     (b_words[idx_q]),
    .sub   (sub_q),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      idx_d   = '0;
      carry_d = sub;
    end else if (running) begin
      carry_d = slice_cout;
      idx_d   = idx_q + 1'b1;
      if (last_slice) begin
        cout_d = slice_cout;
        ovf_d  = slice_cmsb ^ slice_cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

`ifdef ADDSUB_SEQ_ZFLAG_EN
  // Sticky "every slice so far was zero"; published on the final slice.
  logic zacc_q, zacc_d, zero_q, zero_d, zacc_next;

  assign zacc_next = zacc_q & (slice_s == '0);

  always_comb begin
    zacc_d = zacc_q;
    zero_d = zero_q;
    if (accept) begin
      zacc_d = 1'b1;
    end else if (running) begin
      zacc_d = zacc_next;
      if (last_slice) zero_d = zacc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zacc_q <= 1'b1;
      zero_q <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`else
  // Without the zero flag the datapath is unchanged; no extra state is kept.
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq at N=4, WORDS=4; checks zero only when
// ADDSUB_SEQ_ZFLAG_EN is defined.
module tb_addsub_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;
`ifdef ADDSUB_SEQ_ZFLAG_EN
  logic         zero;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  addsub_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
`ifdef ADDSUB_SEQ_ZFLAG_EN
    ,
    .zero   (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t       e;
    logic [W:0] full;
    if (sv) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    full = {1'b0, av} + {1'b0, bv};
    e.res = full[W-1:0];
    e.c   = full[W];
    if (sv) e.v = (av[W-1] != bv[W-1]) && (e.res[W-1] != av[W-1]);
    else    e.v = (av[W-1] == bv[W-1]) && (e.res[W-1] != av[W-1]);
    e.z   = (e.res == '0);
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_cout"},   32'(cout),   32'(e.c));
    check({tag, "_ovf"},    32'(ovf),    32'(e.v));
`ifdef ADDSUB_SEQ_ZFLAG_EN
    check({tag, "_zero"},   32'(zero),   32'(e.z));
`endif
  endtask

  // One operation: drive start at a negedge, optionally poke start mid-RUN,
  // then pop the scoreboard when done is seen.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input int poke);
    exp_t e;
    int   cyc = 0;
    int   busy_n = 0;
    bit   seen = 0;
    bit   overlap = 0;
    sb.push_back(model(av, bv, sv));
    start = 1'b1; a = av; b = bv; sub = sv;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~sv;
      end
      if (poke > 0 && cyc == poke) begin start = 1'b1; a = 16'hAAAA; end
      if (poke > 0 && cyc == poke + 1) start = 1'b0;
      if (busy && done) overlap = 1;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(WORDS + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WORDS));
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'(0));
    e = sb.pop_front();
    if (seen) compare_outputs(tag, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_hold"}, 32'(result), 32'(e.res));
    $display("op %s a=0x%04h b=0x%04h sub=%0b -> result=0x%04h cout=%0b ovf=%0b",
             tag, av, bv, sv, result, cout, ovf);
  endtask

  initial begin
    exp_t e2;
    int   gap;
    int   cyc;

    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),   32'(0));
    check("rst_done",   32'(done),   32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_cout",   32'(cout),   32'(0));
    check("rst_ovf",    32'(ovf),    32'(0));
`ifdef ADDSUB_SEQ_ZFLAG_EN
    check("rst_zero",   32'(zero),   32'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 0);
    do_op("sub_borrow", 16'h0006, 16'h0007, 1'b1, 0);
    do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 0);
    do_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("sub_equal",  16'h5A5A, 16'h5A5A, 1'b1, 0);
    do_op("mid_start",  16'h0123, 16'h0456, 1'b0, 2);
    do_op("add_rand",   W'($urandom), W'($urandom), 1'b0, 0);
    do_op("sub_rand",   W'($urandom), W'($urandom), 1'b1, 0);

    // Reset during RUN aborts the operation and clears outputs.
    start = 1'b1; a = 16'h1234; b = 16'h0FFF; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy",   32'(busy),   32'(0));
    check("midrst_done",   32'(done),   32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_cout",   32'(cout),   32'(0));
    check("midrst_ovf",    32'(ovf),    32'(0));
    @(negedge clk);
    check("midrst_idle", 32'(busy), 32'(0));
    $display("op mid_reset -> result=0x%04h busy=%0b", result, busy);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 0);

    // start held high: re-accepted in the first IDLE cycle after DONE.
    e2 = model(16'h0F0F, 16'h1111, 1'b0);
    start = 1'b1; a = 16'h0F0F; b = 16'h1111; sub = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("held_first_latency", 32'(cyc), 32'(WORDS + 1));
    gap = 0;
    do begin @(negedge clk); gap++; end while (!done && gap < 20);
    start = 1'b0;
    check("held_rearm_gap", 32'(gap), 32'(WORDS + 2));
    compare_outputs("held_second", e2);
    $display("op held_start gap=%0d result=0x%04h", gap, result);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
